// File: rtl/fpcvt_seq.sv
// Sequential integer to sign/exponent/significand converter, one normalising shift per cycle.
// Define FPCVT_ROUND_EN for round-to-nearest; otherwise the dropped bits are truncated.
module fpcvt_seq #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exponent,
  output logic [MAN_W-1:0] significand,
  output logic             sat
);

  localparam int MW = IN_W - 1;
  localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};

  generate
    if (IN_W != MAN_W + 2**EXP_W) begin : g_bad_params
      $error("fpcvt_seq: IN_W must equal MAN_W + 2**EXP_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    mag_q, mag_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             signPend_q, signPend_d;
  logic             satPend_q, satPend_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] sig_q, sig_d;
  logic             sat_q, sat_d;

  logic [IN_W-1:0]  absVal;
  logic             isMinNeg;
  logic [MAN_W-1:0] fracF;
  logic             roundBit;

  assign absVal   = in_data[IN_W-1] ? (~in_data + 1'b1) : in_data;
  assign isMinNeg = (in_data == {1'b1, {(IN_W-1){1'b0}}});
  assign fracF    = mag_q[MW-1 -: MAN_W];
  assign roundBit = mag_q[MW-1-MAN_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      cnt_q      <= '0;
      signPend_q <= 1'b0;
      satPend_q  <= 1'b0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sig_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      signPend_q <= signPend_d;
      satPend_q  <= satPend_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sig_q      <= sig_d;
      sat_q      <= sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    signPend_d = signPend_q;
    satPend_d  = satPend_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sig_d      = sig_q;
    sat_d      = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          signPend_d = in_data[IN_W-1];
          satPend_d  = isMinNeg;
          mag_d      = isMinNeg ? {MW{1'b1}} : absVal[MW-1:0];
          cnt_d      = EMAX;
          state_d    = NORM;
        end
      end
      NORM: begin
        if ((cnt_q == '0) || mag_q[MW-1]) begin
          sign_d  = signPend_q;
          sig_d   = fracF;
          exp_d   = cnt_q;
          sat_d   = satPend_q;
`ifdef FPCVT_ROUND_EN
          // A round-up of an all-ones significand carries into the exponent, or clamps at EMAX.
          if (roundBit) begin
            if (fracF != {MAN_W{1'b1}}) begin
              sig_d = fracF + 1'b1;
            end else if (cnt_q != EMAX) begin
              sig_d = {1'b1, {(MAN_W-1){1'b0}}};
              exp_d = cnt_q + 1'b1;
            end else begin
              sat_d = 1'b1;
            end
          end
`endif
          state_d = DONE;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sign        = sign_q;
  assign exponent    = exp_q;
  assign significand = sig_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_fpcvt_seq.sv
// Randomised and directed bench for fpcvt_seq against an arithmetic reference model.
module tb_fpcvt_seq;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int EMAX  = 2**EXP_W - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [EXP_W-1:0] exponent;
  logic [MAN_W-1:0] significand;
  logic             sat;

  int total = 0;
  int bad   = 0;

  fpcvt_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exponent(exponent), .significand(significand), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Value is F * 2**E: pick the smallest E that fits the magnitude in MAN_W bits, then round.
  task automatic refModel(input logic [IN_W-1:0] d, output int eSign, output int eExp,
                          output int eSig, output int eSat, output int eLat);
    int v, m, bl;
    v = int'($signed(d));
    eSat = 0;
    if (d == 12'h800) begin
      m = 2**(IN_W-1) - 1;
      eSat = 1;
    end else begin
      m = (v < 0) ? -v : v;
    end
    bl = 0;
    for (int i = 0; i < IN_W; i++) if ((m >> i) != 0) bl = i + 1;
    eExp = (bl > MAN_W) ? bl - MAN_W : 0;
    eLat = EMAX - eExp + 1;
    eSig = m >> eExp;
`ifdef FPCVT_ROUND_EN
    if (eExp > 0 && ((m >> (eExp - 1)) & 1) == 1) begin
      eSig = eSig + 1;
      if (eSig == 2**MAN_W) begin
        if (eExp < EMAX) begin
          eSig = 2**(MAN_W-1);
          eExp = eExp + 1;
        end else begin
          eSig = 2**MAN_W - 1;
          eSat = 1;
        end
      end
    end
`endif
    eSign = d[IN_W-1];
  endtask

  task automatic checkResult(input string tag, input int eSign, input int eExp,
                             input int eSig, input int eSat);
    checkOutput({tag, ".sign"}, sign, eSign);
    checkOutput({tag, ".exp"}, exponent, eExp);
    checkOutput({tag, ".sig"}, significand, eSig);
    checkOutput({tag, ".sat"}, sat, eSat);
  endtask

  task automatic acceptSample(input logic [IN_W-1:0] d);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Feed one sample, hold back-pressure for holdCycles, then hand the result off.
  task automatic applyStimulus(input string tag, input logic [IN_W-1:0] d, input int holdCycles);
    int eSign, eExp, eSig, eSat, eLat, cycles;
    refModel(d, eSign, eExp, eSig, eSat, eLat);
    acceptSample(d);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, ".latency"}, cycles, eLat);
    checkResult(tag, eSign, eExp, eSig, eSat);
    for (int i = 0; i < holdCycles; i++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      @(posedge clk); #1;
      checkOutput({tag, ".hold_valid"}, out_valid, 1);
      checkOutput({tag, ".hold_ready"}, in_ready, 0);
      checkResult({tag, ".hold"}, eSign, eExp, eSig, eSat);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, ".valid_fall"}, out_valid, 0);
    checkOutput({tag, ".ready_rise"}, in_ready, 1);
  endtask

  initial begin
    logic [IN_W-1:0] r;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset.in_ready", in_ready, 1);
    checkOutput("reset.out_valid", out_valid, 0);
    checkResult("reset", 0, 0, 0, 0);
    rst = 1'b0;

    applyStimulus("zero", 12'h000, 0);
    applyStimulus("pos125", 12'h07D, 0);
    applyStimulus("neg125", 12'hF83, 0);
    applyStimulus("max", 12'h7FF, 0);
    applyStimulus("minneg", 12'h800, 0);
    applyStimulus("denorm13", 12'h00D, 0);
    applyStimulus("backpress", 12'h0A7, 6);
    applyStimulus("after_bp", 12'h123, 0);

    // Reset asserted during the third NORM cycle of a denormal sample.
    acceptSample(12'h00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst.in_ready", in_ready, 1);
    checkOutput("midrst.out_valid", out_valid, 0);
    checkResult("midrst", 0, 0, 0, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      checkOutput("midrst.no_valid", seen, 0);
    end
    applyStimulus("post_rst125", 12'h07D, 0);

    for (int n = 0; n < 60; n++) begin
      r = IN_W'($urandom);
      if (n % 3 == 1) r = r >> $urandom_range(0, IN_W - 1);
      applyStimulus("rand", r, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
